// File: rtl/rca_result_stage.sv
// Result stage behind the ripple-carry adder: valid/ready capture into a DEPTH-entry FIFO, one-cycle latency, in_ready = !full (no bypass).
// Define RCA_SAT_EN to clamp signed overflow to the representable limit; overflow events are counted (saturating) in both builds.
module rca_result_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout,
    output logic             out_sat,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = WIDTH + 2;
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             full, empty, push, pop;
    logic [WIDTH-1:0] store_data;
    logic             store_sat;
    logic [EW-1:0]    head;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = out_ready && !empty;

`ifdef RCA_SAT_EN
    // A negative-looking sum on overflow means the true result was too large.
    always_comb begin
        store_data = in_sum;
        store_sat  = 1'b0;
        if (in_overflow) begin
            store_sat  = 1'b1;
            store_data = in_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                         : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign store_data = in_sum;
    assign store_sat  = 1'b0;
`endif

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) begin
            ovf_cnt_d = (push && in_overflow) ? CNT_ONE : '0;
        end else if (push && in_overflow && (ovf_cnt_q != CNT_MAX)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // Storage needs no reset: outputs are gated by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {store_sat, in_cout, store_data};
        end
    end

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign out_data  = empty ? '0   : head[WIDTH-1:0];
    assign out_cout  = empty ? 1'b0 : head[WIDTH];
    assign out_sat   = empty ? 1'b0 : head[WIDTH+1];
    assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_rca_result_stage.sv
// Self-checking bench for rca_result_stage: directed steps plus random traffic against a queue-based reference model.
module tb_rca_result_stage;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;
`ifdef RCA_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, in_cout, in_overflow;
    logic             out_valid, out_ready, out_cout, out_sat, ovf_clr;
    logic [WIDTH-1:0] in_sum, out_data;
    logic [CNT_W-1:0] ovf_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic             sat;
        logic             cout;
        logic [WIDTH-1:0] data;
    } ent_t;

    ent_t mq[$];
    int   mcnt;

    always #5 clk = ~clk;

    rca_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cout(out_cout), .out_sat(out_sat),
        .ovf_clr(ovf_clr), .ovf_count(ovf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what a result becomes once captured, from signed arithmetic.
    function automatic ent_t model_entry(input logic [WIDTH-1:0] s, input logic c, input logic o);
        ent_t e;
        int   sv;
        sv     = $signed(s);
        e.cout = c;
        e.sat  = 1'b0;
        e.data = s;
        if (SAT && o) begin
            e.sat  = 1'b1;
            e.data = (sv < 0) ? WIDTH'((1 << (WIDTH-1)) - 1) : WIDTH'(-(1 << (WIDTH-1)));
        end
        return e;
    endfunction

    // Compare all outputs with the model, then advance one clock and update the model.
    task automatic cycle();
        bit do_push, do_pop;
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("out_data", out_data, mq[0].data);
            chk("out_cout", out_cout, mq[0].cout);
            chk("out_sat", out_sat, mq[0].sat);
        end else begin
            chk("out_data_empty", out_data, 0);
            chk("out_cout_empty", out_cout, 0);
            chk("out_sat_empty", out_sat, 0);
        end
        chk("ovf_count", ovf_count, mcnt);
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(model_entry(in_sum, in_cout, in_overflow));
            if (ovf_clr) mcnt = (do_push && in_overflow) ? 1 : 0;
            else if (do_push && in_overflow && mcnt < (1 << CNT_W) - 1) mcnt = mcnt + 1;
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] s, input bit c, input bit o);
        in_valid = v; in_sum = s; in_cout = c; in_overflow = o;
    endtask

    initial begin
        logic [WIDTH-1:0] vals [3];
        vals[0] = 8'hFA; vals[1] = 8'hDE; vals[2] = 8'h7F;
        rst = 1'b1; ovf_clr = 1'b0; out_ready = 1'b0;
        drive(0, '0, 0, 0);
        @(posedge clk); #1;
        mq.delete(); mcnt = 0;
        rst = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_ovf_count", ovf_count, 0);

        // 1: +127 + +1 wraps to -128
        out_ready = 1'b1;
        drive(1, 8'h80, 0, 1); cycle();
        drive(0, '0, 0, 0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_data", out_data, SAT ? 8'h7F : 8'h80);
        chk("t1_out_sat", out_sat, SAT);
        chk("t1_ovf_count", ovf_count, 1);
        cycle();

        // 2: -128 + -1 wraps to +127 with carry out
        drive(1, 8'h7F, 1, 1); cycle();
        drive(0, '0, 0, 0);
        chk("t2_out_data", out_data, SAT ? 8'h80 : 8'h7F);
        chk("t2_out_cout", out_cout, 1);
        chk("t2_out_sat", out_sat, SAT);
        cycle();

        // 3: fill with out_ready low, third push held off
        out_ready = 1'b0;
        drive(1, 8'h05, 0, 0); cycle();
        drive(1, 8'hFB, 0, 0); cycle();
        chk("t3_full_in_ready", in_ready, 0);
        drive(1, 8'h00, 0, 0); cycle();
        cycle();
        out_ready = 1'b1;
        chk("t3_head_first", out_data, 8'h05);
        cycle();
        chk("t3_head_second", out_data, 8'hFB);
        chk("t3_in_ready_back", in_ready, 1);
        cycle();
        drive(0, '0, 0, 0);
        chk("t3_third_out", out_data, 8'h00);
        chk("t3_third_valid", out_valid, 1);
        cycle();
        cycle();

        // 4: streaming across pointer wrap
        for (int i = 0; i < 20; i++) begin
            drive(1, vals[i % 3], 0, 0);
            cycle();
        end
        drive(0, '0, 0, 0);
        cycle(); cycle();

        // 5: counter saturation, then clear with a simultaneous overflow push
        for (int i = 0; i < 260; i++) begin
            drive(1, WIDTH'($urandom), 1'($urandom), 1);
            cycle();
        end
        drive(0, '0, 0, 0);
        chk("t5_ovf_sat", ovf_count, 255);
        cycle();
        cycle();
        ovf_clr = 1'b1;
        drive(1, 8'h90, 0, 1); cycle();
        ovf_clr = 1'b0;
        drive(0, '0, 0, 0);
        chk("t5_clr_plus_push", ovf_count, 1);
        cycle(); cycle();

        // 6: reset with two entries buffered
        out_ready = 1'b0;
        drive(1, 8'h11, 0, 1); cycle();
        drive(1, 8'h22, 1, 0); cycle();
        drive(0, '0, 0, 0);
        chk("t6_full_before_rst", out_valid, 1);
        rst = 1'b1; cycle();
        rst = 1'b0;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_ovf_count", ovf_count, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), 1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0; ovf_clr = 1'b0;
        drive(0, '0, 0, 0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rca_result_stage.md
Name: rca_result_stage

Overview:
Downstream consumer of the RippleCarryAdder. Captures each adder result (Sum, Cout, Overflow) under a valid/ready handshake and optionally saturates signed overflow to the representable limit. Buffers results in a small FIFO and exposes them to the next stage. Keeps a saturating count of overflow events for status/debug.

Parameters:
WIDTH, 8, adder data width in bits; must match the RippleCarryAdder WIDTH.
DEPTH, 2, number of FIFO entries; must be a power of two, minimum 2.
CNT_W, 8, width of the overflow event counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  adder result on in_sum/in_cout/in_overflow is valid.
in_ready  output  1  stage can accept a result this cycle.
in_sum  input  WIDTH  signed Sum from the adder.
in_cout  input  1  Cout from the adder.
in_overflow  input  1  Overflow from the adder.
out_valid  output  1  head FIFO entry is valid.
out_ready  input  1  downstream accepts the head entry this cycle.
out_data  output  WIDTH  signed result; saturated when RCA_SAT_EN is defined.
out_cout  output  1  captured Cout of the head entry.
out_sat  output  1  head entry was saturated (RCA_SAT_EN only; otherwise 0).
ovf_clr  input  1  synchronous clear of ovf_count.
ovf_count  output  CNT_W  number of accepted results with in_overflow=1.

Behaviour:
- Reset (rst=1 at a clk edge): FIFO emptied, pointers 0, out_valid=0, in_ready=1 from the following cycle, ovf_count=0. out_data, out_cout, and out_sat read 0 while the FIFO is empty. Reset mid-operation discards all buffered entries.
- Accept: a push occurs when in_valid && in_ready. A pop occurs when out_valid && out_ready.
- in_ready = !full. It depends only on registered state, with no combinational path from out_ready. A pop in the same cycle does not open a slot while the FIFO is full.
- out_valid = !empty. out_data, out_cout, and out_sat are driven from the head entry.
- Latency: a push into an empty FIFO gives out_valid=1 on the next cycle. There is no combinational bypass.
- Simultaneous push and pop, FIFO neither empty nor full: occupancy is unchanged and both pointers advance.
- Pop when empty or push when full is impossible by construction. Inputs are ignored when in_valid=0.
- Pointers are log2(DEPTH) bits plus one wrap bit. They wrap modulo DEPTH. Full means the indices are equal and the wrap bits differ.
- Stored word per entry: {sat, cout, data}.
- ovf_count increments by 1 on each push with in_overflow=1 and saturates at 2^CNT_W-1 without wrapping.
- ovf_clr=1 sets ovf_count to 0. If a push with overflow happens in the same cycle, ovf_count becomes 1.
- Out-of-reset order of precedence: rst > ovf_clr > increment.

Optional Feature:
RCA_SAT_EN.
- Defined: on a push with in_overflow=1, the stored data is saturated.
  - in_sum MSB=1 (positive overflow wrapped negative) stores the max positive value, 0 followed by all 1s.
  - in_sum MSB=0 stores the min negative value, 1 followed by all 0s.
  - The entry's sat bit is set to 1.
  - With in_overflow=0, in_sum is stored unchanged and sat=0.
- Undefined: in_sum is always stored unchanged (two's-complement wrap) and out_sat is tied to 0. ovf_count behaves the same in both builds.

Test Plan:
1. Reset, then push in_sum=-128, in_overflow=1 (from +127 + +1) with out_ready=1. Required: next cycle out_valid=1, out_data=+127, out_sat=1, ovf_count=1 (with RCA_SAT_EN). Without RCA_SAT_EN: out_data=-128, out_sat=0.
2. Push in_sum=+127, in_overflow=1, in_cout=1 (from -128 + -1). Required: out_data=-128, out_cout=1, out_sat=1 with RCA_SAT_EN; out_data=+127 without it.
3. Hold out_ready=0 and push +5, -5, +0 on consecutive cycles with DEPTH=2. Required: in_ready drops to 0 after the second push and the third is held off. Then raise out_ready: +5 and -5 drain in order and the third value is accepted only after in_ready returns to 1.
4. Sustained streaming with in_valid=1, out_ready=1 for 20 cycles using values -6, -34, +127 (no overflow). Required: one result per cycle, order preserved, no wrap corruption across pointer wrap.
5. Drive 260 overflow pushes with CNT_W=8. Required: ovf_count stops at 255. Then assert ovf_clr together with an overflow push; required: ovf_count=1.
6. Assert rst while the FIFO holds 2 entries. Required: the next cycle has out_valid=0, in_ready=1, ovf_count=0, and no stale data is emitted afterwards.
